// File: rtl/alpha_blend_pipe.sv
// Two-stage alpha blender (products, then sum/shift/mode select) with colour key, tag sideband and per-frame fade.
// Latency 2 cycles; output holds under out_ready=0, input stalls only when both stages are full and blocked.
module alpha_blend_pipe #(
    parameter int CW  = 4,
    parameter int NCH = 3,
    parameter int AW  = 3,
    parameter int TW  = 21
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [1:0]        mode_in,
    input  logic [AW-1:0]     alpha_in,
    input  logic [NCH*CW-1:0] key_in,
    input  logic              fade_en_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*CW-1:0] in_a,
    input  logic [NCH*CW-1:0] in_b,
    input  logic [TW-1:0]     in_tag,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*CW-1:0] out_pixel,
    output logic [TW-1:0]     out_tag,
    output logic [AW-1:0]     alpha_cur_out
);
    localparam int PW  = NCH * CW;
    localparam int PRW = CW + AW;
    localparam int SMW = PRW + 1;
    localparam logic [AW-1:0] FS = AW'(1 << (AW - 1));

    typedef enum logic [1:0] {
        MODE_BLEND     = 2'b00,
        MODE_BOTH      = 2'b01,
        MODE_KEYED     = 2'b10,
        MODE_PASS_A    = 2'b11
    } mode_t;

    logic [AW-1:0]           alpha_cur;
    logic [AW-1:0]           alpha_c;
    logic [AW-1:0]           alpha_n;
    logic                    in_fire;
    logic                    s2_open;
    logic                    s2_valid;

    logic                    s1_valid;
    logic [PW-1:0]           s1_a;
    logic [PW-1:0]           s1_b;
    logic [PW-1:0]           s1_key;
    logic [TW-1:0]           s1_tag;
    mode_t                   s1_mode;
    logic [NCH-1:0][PRW-1:0] s1_pa;
    logic [NCH-1:0][PRW-1:0] s1_pb;

    logic [NCH-1:0][PRW-1:0] prod_a;
    logic [NCH-1:0][PRW-1:0] prod_b;
    logic [NCH-1:0][SMW-1:0] sum;
    logic [PW-1:0]           blend_pix;
    logic [PW-1:0]           sel_pix;

    assign alpha_c       = (alpha_in > FS) ? FS : alpha_in;
    assign alpha_n       = FS - alpha_cur;
    assign s2_open       = !s2_valid || out_ready;
    assign in_ready      = !s1_valid || s2_open;
    assign in_fire       = in_valid && in_ready;
    assign out_valid     = s2_valid;
    assign alpha_cur_out = alpha_cur;

    // The sof pixel is weighted with the pre-step alpha; the step lands with it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alpha_cur <= '0;
        end else if (!fade_en_in) begin
            alpha_cur <= alpha_c;
        end else if (in_fire && in_sof) begin
            if (alpha_cur < alpha_c) begin
                alpha_cur <= alpha_cur + AW'(1);
            end else if (alpha_cur > alpha_c) begin
                alpha_cur <= alpha_cur - AW'(1);
            end
        end
    end

    always_comb begin
        prod_a = '0;
        prod_b = '0;
        for (int k = 0; k < NCH; k++) begin
            prod_a[k] = PRW'(in_a[k*CW +: CW]) * PRW'(alpha_cur);
            prod_b[k] = PRW'(in_b[k*CW +: CW]) * PRW'(alpha_n);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_key   <= '0;
            s1_tag   <= '0;
            s1_mode  <= MODE_BLEND;
            s1_pa    <= '0;
            s1_pb    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a    <= in_a;
                s1_b    <= in_b;
                s1_key  <= key_in;
                s1_tag  <= in_tag;
                s1_mode <= mode_t'(mode_in);
                s1_pa   <= prod_a;
                s1_pb   <= prod_b;
            end
        end
    end

    // Sum never exceeds (2^CW-1)*FS, so the shifted result always fits CW bits.
    always_comb begin
        sum       = '0;
        blend_pix = '0;
        for (int k = 0; k < NCH; k++) begin
            sum[k] = SMW'(s1_pa[k]) + SMW'(s1_pb[k]);
            blend_pix[k*CW +: CW] = CW'(sum[k] >> (AW - 1));
        end
    end

    always_comb begin
        sel_pix = blend_pix;
        case (s1_mode)
            MODE_BLEND:  sel_pix = blend_pix;
            MODE_BOTH:   sel_pix = ((s1_a != '0) && (s1_b != '0)) ? blend_pix : (s1_a | s1_b);
            MODE_KEYED:  sel_pix = (s1_b == s1_key) ? s1_a : s1_b;
            MODE_PASS_A: sel_pix = s1_a;
            default:     sel_pix = blend_pix;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_valid  <= 1'b0;
            out_pixel <= '0;
            out_tag   <= '0;
        end else if (s2_open) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_pixel <= sel_pix;
                out_tag   <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Bench for alpha_blend_pipe: directed scenarios plus random traffic against a queue-based reference model.
module tb_alpha_blend_pipe;
    localparam int PW = 12;
    localparam int TW = 21;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b1;
    logic [1:0]    mode_in = 2'd0;
    logic [2:0]    alpha_in = 3'd0;
    logic [PW-1:0] key_in = '0;
    logic          fade_en_in = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_a = '0;
    logic [PW-1:0] in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          in_sof = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_pixel;
    logic [TW-1:0] out_tag;
    logic [2:0]    alpha_cur_out;

    int            checks = 0;
    int            fails = 0;
    int            alpha_m = 0;
    int            n_drain = 0;
    logic [PW-1:0] qpix[$];
    logic [TW-1:0] qtag[$];
    bit            head_out = 1'b0;
    int            up_seq[5] = '{1, 2, 3, 4, 4};
    int            dn_seq[4] = '{3, 2, 1, 1};

    alpha_blend_pipe dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .mode_in(mode_in), .alpha_in(alpha_in),
        .key_in(key_in), .fade_en_in(fade_en_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_tag(out_tag), .alpha_cur_out(alpha_cur_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input logic [2:0] a);
        return (int'(a) > 4) ? 4 : int'(a);
    endfunction

    function automatic logic [PW-1:0] ref_pix(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [PW-1:0] key, input logic [1:0] mode,
                                             input int m);
        logic [PW-1:0] bl;
        bl = '0;
        for (int k = 0; k < 3; k++) begin
            bl[k*4 +: 4] = 4'((int'(a[k*4 +: 4]) * m + int'(b[k*4 +: 4]) * (4 - m)) / 4);
        end
        case (mode)
            2'd0:    return bl;
            2'd1:    return (a != 0 && b != 0) ? bl : (a | b);
            2'd2:    return (b == key) ? a : b;
            default: return a;
        endcase
    endfunction

    // One clock: check ready, advance the model across the edge, then check outputs.
    task automatic tick();
        bit            fire;
        bit            drain;
        bit            exp_rdy;
        logic [PW-1:0] ep;
        #1;
        exp_rdy = (qpix.size() < 2) || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        fire  = in_valid && exp_rdy;
        drain = (qpix.size() > 0) && head_out && out_ready;
        if (out_valid && out_ready) n_drain++;
        ep = ref_pix(in_a, in_b, key_in, mode_in, alpha_m);
        @(posedge clk_in);
        if (drain) begin
            void'(qpix.pop_front());
            void'(qtag.pop_front());
            head_out = 1'b0;
        end
        if (qpix.size() > 0 && !head_out) head_out = 1'b1;
        if (fire) begin
            qpix.push_back(ep);
            qtag.push_back(in_tag);
        end
        if (!fade_en_in) alpha_m = clamp(alpha_in);
        else if (fire && in_sof) begin
            if (alpha_m < clamp(alpha_in)) alpha_m++;
            else if (alpha_m > clamp(alpha_in)) alpha_m--;
        end
        @(negedge clk_in);
        chk("out_valid", out_valid, (qpix.size() > 0) && head_out);
        chk("alpha_cur", alpha_cur_out, alpha_m);
        if (qpix.size() > 0 && head_out) begin
            chk("out_pixel", out_pixel, qpix[0]);
            chk("out_tag", out_tag, qtag[0]);
        end
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alpha", alpha_cur_out, 0);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_out_tag", out_tag, 0);
        qpix.delete();
        qtag.delete();
        head_out = 1'b0;
        alpha_m  = 0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic drive(input logic [PW-1:0] a, input logic [PW-1:0] b,
                         input logic [TW-1:0] tag, input logic sof);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        in_sof   = sof;
    endtask

    initial begin
        #2;
        do_reset();

        // Plain blend at half alpha, two-cycle latency.
        fade_en_in = 1'b0; mode_in = 2'd0; alpha_in = 3'd2; out_ready = 1'b1;
        tick();
        drive(12'hF00, 12'h0F0, 21'h12345, 1'b0); tick();
        in_valid = 1'b0; tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_pix", out_pixel, 12'h770);
        chk("t1_tag", out_tag, 21'h12345);
        tick();

        // Alpha clamp to full scale.
        alpha_in = 3'd7; tick();
        chk("t2_alpha", alpha_cur_out, 4);
        drive(12'h5A3, 12'hFFF, 21'h00042, 1'b0); tick();
        in_valid = 1'b0; tick();
        chk("t2_pix", out_pixel, 12'h5A3);

        // Blend-if-both.
        mode_in = 2'd1; alpha_in = 3'd2; tick();
        drive(12'h123, 12'h000, 21'd1, 1'b0); tick();
        drive(12'h888, 12'h444, 21'd2, 1'b0); tick();
        in_valid = 1'b0;
        chk("t3_one_zero", out_pixel, 12'h123);
        tick();
        chk("t3_both", out_pixel, 12'h666);
        tick();

        // Keyed with a key change between back-to-back pixels.
        mode_in = 2'd2; key_in = 12'h000;
        drive(12'hABC, 12'h000, 21'd3, 1'b0); tick();
        drive(12'h111, 12'h0F0, 21'd4, 1'b0); tick();
        chk("t4_key_hit", out_pixel, 12'hABC);
        key_in = 12'h0F0;
        drive(12'h222, 12'h0F0, 21'd5, 1'b0); tick();
        in_valid = 1'b0;
        chk("t4_key_miss", out_pixel, 12'h0F0);
        tick();
        chk("t4_new_key", out_pixel, 12'h222);
        tick();

        // Backpressure: capacity two, output held while stalled.
        mode_in = 2'd3; out_ready = 1'b0;
        drive(12'hA01, 12'h000, 21'd6, 1'b0); tick();
        drive(12'hA02, 12'h000, 21'd7, 1'b0); tick();
        drive(12'hA03, 12'h000, 21'd8, 1'b0);
        #1 chk("t5_ready_low", in_ready, 0);
        tick();
        chk("t5_stall_pix", out_pixel, 12'hA01);
        tick();
        chk("t5_hold_pix", out_pixel, 12'hA01);
        chk("t5_hold_valid", out_valid, 1);
        n_drain = 0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t5_out2", out_pixel, 12'hA02);
        tick();
        chk("t5_out3", out_pixel, 12'hA03);
        tick(); tick();
        chk("t5_count", n_drain, 3);

        // Fade engine: steps up once per sof, then down, then reset mid-stream.
        fade_en_in = 1'b1; alpha_in = 3'd4; mode_in = 2'd0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(12'($urandom), 12'($urandom), 21'(i), 1'b1); tick();
            chk("t6_fade_up", alpha_cur_out, up_seq[i]);
        end
        alpha_in = 3'd1;
        for (int i = 0; i < 4; i++) begin
            drive(12'($urandom), 12'($urandom), 21'(i + 8), 1'b1); tick();
            chk("t6_fade_down", alpha_cur_out, dn_seq[i]);
        end
        do_reset();

        // Fresh behaviour after a mid-stream reset.
        fade_en_in = 1'b0; alpha_in = 3'd2; tick();
        drive(12'hF00, 12'h0F0, 21'h1ABCD, 1'b0); tick();
        in_valid = 1'b0; tick();
        chk("t7_fresh_pix", out_pixel, 12'h770);
        chk("t7_fresh_tag", out_tag, 21'h1ABCD);

        // Random traffic with bubbles, stalls, mode/key/alpha churn and fade toggling.
        for (int seg = 0; seg < 12; seg++) begin
            fade_en_in = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 150; c++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                mode_in   = 2'($urandom_range(0, 3));
                alpha_in  = 3'($urandom_range(0, 7));
                in_a      = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
                in_b      = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
                key_in    = ($urandom_range(0, 1) == 1) ? in_b : 12'($urandom);
                in_tag    = 21'($urandom);
                in_sof    = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
